pe_divider: RTL



---
 rtl/pe_divider_if.sv | 21 ++
 rtl/pe_divider.sv | 119 +++++++++++
 2 files changed

// File: rtl/pe_divider_if.sv
// rtl/pe_divider_if.sv - start/done handshake and operand/result bundle for pe_divider
interface pe_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/pe_divider.sv
// rtl/pe_divider.sv - 8-bit sequential restoring divider, one quotient bit per clock
// Optional PE_DIVIDER_FAST_EXIT_EN: skip CALC when divisor==0 or dividend<divisor.
module pe_divider (
    input  logic          clk,
    input  logic          rst_n,
    pe_divider_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] q_sh;
    logic [7:0] d_reg;
    logic [8:0] r;
    logic [2:0] cnt;
    logic [7:0] quotient_q;
    logic [7:0] remainder_q;
    logic       div_zero_q;

    logic       accept;
    logic       fast;
    logic [8:0] r_shift;
    logic [8:0] trial;
    logic [8:0] r_next;
    logic [7:0] q_next;

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

`ifdef PE_DIVIDER_FAST_EXIT_EN
    assign fast = (bus.divisor == 8'd0) || (bus.dividend < bus.divisor);
`else
    assign fast = 1'b0;
`endif

    // Restoring step: bring in the next dividend bit, keep the trial only if it did not borrow.
    assign r_shift = {r[7:0], q_sh[7]};
    assign trial   = r_shift - {1'b0, d_reg};
    assign r_next  = trial[8] ? r_shift : trial;
    assign q_next  = {q_sh[6:0], ~trial[8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sh        <= 8'd0;
            d_reg       <= 8'd0;
            r           <= 9'd0;
            cnt         <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
        end else if (accept) begin
            q_sh  <= bus.dividend;
            d_reg <= bus.divisor;
            r     <= 9'd0;
            cnt   <= 3'd7;
`ifdef PE_DIVIDER_FAST_EXIT_EN
            if (fast) begin
                quotient_q  <= (bus.divisor == 8'd0) ? 8'hFF : 8'd0;
                remainder_q <= bus.dividend;
                div_zero_q  <= (bus.divisor == 8'd0);
            end
`endif
        end else if (state_q == CALC) begin
            q_sh <= q_next;
            r    <= r_next;
            cnt  <= cnt - 3'd1;
            // Results only move on the completing step so they stay valid through a new CALC.
            if (cnt == 3'd0) begin
                quotient_q  <= q_next;
                remainder_q <= r_next[7:0];
                div_zero_q  <= (d_reg == 8'd0);
            end
        end
    end

    assign bus.busy      = (state_q == CALC);
    assign bus.done      = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

endmodule
